rs_single_err_locator: RTL

// Consumes the four syndromes S0..S3 produced by the RS syndrome calculator for one CIRC codeword (C1 or C2 stage).

---
 rtl/rs_single_err_locator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rs_single_err_locator.sv
// rs_single_err_locator: classifies an RS codeword from syndromes S0..S3 as clean, single-error or uncorrectable.
// A single error yields its position p (alpha^p = S1/S0) and magnitude S0.
module gf256_mult (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] a;
    always_comb begin
        a = i_a;
        o_p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            o_p = i_b[i] ? o_p ^ a : o_p;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
        end
    end
endmodule

// x^-1 = x^254 = x^2 * x^4 * ... * x^128, one square-and-accumulate step per cycle.
module gf256_inv (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_x,
    output logic       o_ready,
    output logic [7:0] o_y
);
    logic [7:0] sq_q, sq_d, acc_q, acc_d, sq_sq, acc_nx;
    logic [2:0] cnt_q, cnt_d;
    logic       run_q, run_d, ready_q, ready_d;

    gf256_mult m_sq (.i_a(sq_q), .i_b(sq_q), .o_p(sq_sq));
    gf256_mult m_acc (.i_a(acc_q), .i_b(sq_sq), .o_p(acc_nx));

    always_comb begin
        sq_d = i_start ? i_x : (run_q ? sq_sq : sq_q);
        acc_d = i_start ? 8'h01 : (run_q ? acc_nx : acc_q);
        cnt_d = i_start ? 3'd0 : (run_q ? cnt_q + 3'd1 : cnt_q);
        run_d = i_start || (run_q && cnt_q != 3'd6);
        ready_d = !i_start && (ready_q || (run_q && cnt_q == 3'd6));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sq_q <= 8'h00;
            acc_q <= 8'h00;
            cnt_q <= 3'd0;
            run_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_y = acc_q;
endmodule

module rs_single_err_locator #(
    parameter int N  = 32,
    parameter int PW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_s0,
    input  logic [7:0]    i_s1,
    input  logic [7:0]    i_s2,
    input  logic [7:0]    i_s3,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_flag,
    output logic [PW-1:0] o_err_pos,
    output logic [7:0]    o_err_mag
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_INV, S_SEARCH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [7:0]    l_q, l_d, p_q, p_d, mag_q, mag_d;
    logic [PW-1:0] k_q, k_d, pos_q, pos_d;
    logic [1:0]    flag_q, flag_d;
    logic          inv_start_q, inv_start_d, done_q, done_d;
    logic [7:0]    s11, s02, s22, s13, inv_y, loc, p_nx;
    logic          inv_ready;

    gf256_mult m_s11 (.i_a(s1_q), .i_b(s1_q), .o_p(s11));
    gf256_mult m_s02 (.i_a(s0_q), .i_b(s2_q), .o_p(s02));
    gf256_mult m_s22 (.i_a(s2_q), .i_b(s2_q), .o_p(s22));
    gf256_mult m_s13 (.i_a(s1_q), .i_b(s3_q), .o_p(s13));
    gf256_mult m_loc (.i_a(s1_q), .i_b(inv_y), .o_p(loc));
    gf256_mult m_pow (.i_a(p_q), .i_b(8'h02), .o_p(p_nx));

    gf256_inv inv (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(inv_start_q), .i_x(s0_q),
        .o_ready(inv_ready), .o_y(inv_y)
    );

    always_comb begin
        state_d = state_q;
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        l_d = l_q;
        p_d = p_q;
        k_d = k_q;
        pos_d = pos_q;
        mag_d = mag_q;
        flag_d = flag_q;
        inv_start_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) begin
                s0_d = i_s0;
                s1_d = i_s1;
                s2_d = i_s2;
                s3_d = i_s3;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if ({s0_q, s1_q, s2_q, s3_q} != 32'h0 && s0_q != 8'h00 && s1_q != 8'h00 && s2_q != 8'h00
                    && s3_q != 8'h00 && s11 == s02 && s22 == s13) begin
                    inv_start_d = 1'b1;
                    state_d = S_INV;
                end else begin
                    flag_d = ({s0_q, s1_q, s2_q, s3_q} == 32'h0) ? 2'b00 : 2'b10;
                    pos_d = '0;
                    mag_d = 8'h00;
                    done_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            // the inverter's ready may still be high from the previous word during the start cycle
            S_INV: if (!inv_start_q && inv_ready) begin
                l_d = loc;
                p_d = 8'h01;
                k_d = '0;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (p_q == l_q || k_q == PW'(N - 1)) begin
                    flag_d = (p_q == l_q) ? 2'b01 : 2'b10;
                    pos_d = (p_q == l_q) ? k_q : '0;
                    mag_d = (p_q == l_q) ? s0_q : 8'h00;
                    done_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    p_d = p_nx;
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            s0_q <= 8'h00;
            s1_q <= 8'h00;
            s2_q <= 8'h00;
            s3_q <= 8'h00;
            l_q <= 8'h00;
            p_q <= 8'h01;
            k_q <= '0;
            pos_q <= '0;
            mag_q <= 8'h00;
            flag_q <= 2'b00;
            inv_start_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            l_q <= l_d;
            p_q <= p_d;
            k_q <= k_d;
            pos_q <= pos_d;
            mag_q <= mag_d;
            flag_q <= flag_d;
            inv_start_q <= inv_start_d;
            done_q <= done_d;
        end
    end

    assign o_busy = state_q != S_IDLE;
    assign o_done = done_q;
    assign o_flag = flag_q;
    assign o_err_pos = pos_q;
    assign o_err_mag = mag_q;
endmodule
